// File: rtl/float_ieee_packer_pkg.sv
// Shared types and constants for the internal-float to IEEE-754 single write-back path.
package float_pack;
  localparam int NM      = 23;
  localparam int NE      = 8;
  localparam int BIAS    = 2**(NE-1) - 1;
  localparam int EXP_INF = 2**NE - 1;
  // Exponent arithmetic is two bits wider than IEEE so neither +1 nor -1 can wrap.
  localparam int EW      = NE + 2;

  typedef struct packed {
    logic          s;
    logic [NE-1:0] exp;
    logic [NM-1:0] frac;
  } ieee_t;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} packer_state_t;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } fp_flags_t;
endpackage

// File: rtl/float_ieee_packer_round.sv
// Round-to-nearest-even of a normalised mantissa with guard/round/sticky; shared by result paths.
module float_round_rne
  import float_pack::*;
(
  input  logic [NM:0]   mant_i,
  input  logic          g_i,
  input  logic          r_i,
  input  logic          st_i,
  input  logic [EW-1:0] exp_i,
  output logic [NM:0]   mant_o,
  output logic [EW-1:0] exp_o,
  output logic          inexact_o
);
  logic          round_up;
  logic [NM+1:0] sum;

  assign round_up  = g_i & (r_i | st_i | mant_i[0]);
  assign sum       = {1'b0, mant_i} + {{(NM+1){1'b0}}, 1'b1};
  assign inexact_o = g_i | r_i | st_i;

  always_comb begin
    mant_o = mant_i;
    exp_o  = exp_i;
    if (round_up) begin
      // A carry out of the mantissa renormalises to 1.0 with the exponent bumped.
      if (sum[NM+1]) begin
        mant_o = {1'b1, {NM{1'b0}}};
        exp_o  = exp_i + EW'(1);
      end else begin
        mant_o = sum[NM:0];
      end
    end
  end
endmodule

// File: rtl/float_ieee_packer.sv
// Packs the coprocessor's unnormalised internal float into an IEEE-754 single word.
module float_ieee_packer
  import float_pack::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NE+NM+2:0]  in_float,
  input  logic              in_carry,
  input  logic [2:0]        in_grs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NE+NM:0]    out_ieee,
  output logic [2:0]        out_flags
);
  packer_state_t state_q;
  logic          sign_q;
  logic [EW-1:0] exp_q;
  logic          carry_q;
  logic [NM:0]   mant_q;
  logic          g_q, r_q, st_q;
  logic          out_valid_q;
  ieee_t         out_ieee_q;
  fp_flags_t     flags_q;

  logic [NM:0]   rnd_mant;
  logic [EW-1:0] rnd_exp;
  logic          rnd_inexact;
  logic          unused_rnd_msb;

  float_round_rne u_round (
    .mant_i    (mant_q),
    .g_i       (g_q),
    .r_i       (r_q),
    .st_i      (st_q),
    .exp_i     (exp_q),
    .mant_o    (rnd_mant),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inexact)
  );

  // The hidden bit is implied by the IEEE encoding.
  assign unused_rnd_msb = rnd_mant[NM];

  assign in_ready  = (state_q == IDLE) && !rst_i;
  assign out_valid = out_valid_q;
  assign out_ieee  = out_ieee_q;
  assign out_flags = flags_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      carry_q     <= 1'b0;
      mant_q      <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      st_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_ieee_q  <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_float[NE+NM+2];
            exp_q   <= {1'b0, in_float[NE+NM+1:NM+1]};
            mant_q  <= in_float[NM:0];
            carry_q <= in_carry;
            g_q     <= in_grs[2];
            r_q     <= in_grs[1];
            st_q    <= in_grs[0];
            state_q <= NORM;
          end
        end
        NORM: begin
          if (carry_q) begin
            mant_q  <= {1'b1, mant_q[NM:1]};
            g_q     <= mant_q[0];
            r_q     <= g_q;
            st_q    <= st_q | r_q;
            exp_q   <= exp_q + EW'(1);
            carry_q <= 1'b0;
          end else if (mant_q == '0 && !g_q && !r_q && !st_q) begin
            out_ieee_q  <= '{s: sign_q, exp: '0, frac: '0};
            flags_q     <= '0;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (exp_q == '0 || (!mant_q[NM] && exp_q == EW'(1))) begin
            // Below the normal range: flush to signed zero (no subnormals).
            out_ieee_q  <= '{s: sign_q, exp: '0, frac: '0};
            flags_q     <= '{ovf: 1'b0, unf: 1'b1, inx: g_q | r_q | st_q};
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (!mant_q[NM]) begin
            mant_q <= {mant_q[NM-1:0], g_q};
            g_q    <= r_q;
            r_q    <= 1'b0;
            exp_q  <= exp_q - EW'(1);
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (rnd_exp >= EW'(EXP_INF)) begin
            out_ieee_q <= '{s: sign_q, exp: '1, frac: '0};
            flags_q    <= '{ovf: 1'b1, unf: 1'b0, inx: 1'b1};
          end else begin
            out_ieee_q <= '{s: sign_q, exp: rnd_exp[NE-1:0], frac: rnd_mant[NM-1:0]};
            flags_q    <= '{ovf: 1'b0, unf: 1'b0, inx: rnd_inexact};
          end
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/float_ieee_packer.md
Name: float_ieee_packer

Overview:
- Converts the coprocessor's internal `float` result into a 32-bit IEEE-754 single word for return to the LM32.
- The internal `float` is an unpacked, possibly unnormalised mantissa with carry and guard/round/sticky bits. This block is the write-back counterpart of the IEEE-to-internal unpack path.
- Sequential: one-bit-per-cycle normaliser, round-to-nearest-even stage, then a valid/ready output register.
- Sits between the arithmetic datapath (add/sub/mul/div) and the LM32 result bus.

Parameters:
- NM, 23, mantissa fraction width. Taken from float_pack Nm; the bench checks IEEE encoding only at 23.
- NE, 8, exponent width. Taken from float_pack Ne; the internal exponent is NE+1 bits.
- BIAS, 2**(NE-1)-1, exponent bias (127).

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- in_float  in  1+(NE+1)+(NM+1)  float_pack `float` {s, exp unsigned biased, mant with explicit leading bit}.
- in_carry  in  1  mantissa bit above mant MSB (value in [2,4)).
- in_grs  in  3  guard, round, sticky bits below mant LSB.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_ieee  out  1+NE+NM  packed IEEE result.
- out_flags  out  3  {overflow, underflow, inexact}.

Behaviour:
- Reset (rst_i high at an edge):
  - state goes to IDLE.
  - out_valid=0, out_ieee=0, out_flags=0, all internal registers cleared.
  - in_ready=0 while rst_i is high.
  - Reset mid-operation discards the operation with no output.
- FSM states: IDLE, NORM, ROUND, OUT.
- in_ready = (state==IDLE) && !rst_i. There is no overlap: one operand is in flight at a time.
- IDLE:
  - On in_valid && in_ready, capture {s, exp, carry, mant, g, r, st} and go to NORM.
- NORM, evaluated once per cycle, first matching rule only:
  - a) carry=1: shift {carry,mant,g,r} right 1, with sticky |= shifted-out r; exp+=1; carry=0. Stay in NORM.
  - b) mant==0 && g==r==st==0: zero result (sign kept); go to OUT.
  - c) exp==0, or (mant MSB==0 && exp==1): flush to signed zero, underflow=1, inexact=|grs; go to OUT.
  - d) mant MSB==0: shift {mant,g,r} left 1, r<=0, sticky held; exp-=1. Stay in NORM.
  - e) otherwise (normalised): go to ROUND.
- ROUND, RNE:
  - Round-up is required when g && (r || st || mant[0]).
  - mant+1 overflowing 24 bits gives mant=1.0 (0x800000) and exp+1.
  - inexact = g|r|st, taken before rounding.
  - exp>=2**NE-1 after rounding gives signed infinity, overflow=1, inexact=1.
  - Otherwise out_ieee = {s, exp[NE-1:0], mant[NM-1:0]}.
  - Register the result and flags, set out_valid, go to OUT.
- OUT:
  - Hold out_valid/out_ieee/out_flags stable until out_ready.
  - On out_valid && out_ready: out_valid<=0, go to IDLE.
  - out_ready high in the same cycle as out_valid means a 1-cycle transfer.
- Zero and flush results go NORM to OUT directly and set out_valid with the same registered update.
- Latency: acceptance edge to out_valid rising = k+2 edges, where k = number of shift cycles (carry counts 1).
  - Normalised input: 2 edges.
  - Zero input: 1 edge.
- Input exp >= 2**NE-1 without carry: passes NORM rule e, then ROUND produces infinity with overflow=1.
- NaN is not represented internally; no NaN output is ever produced.
- Width rules:
  - Exponent arithmetic is done in NE+2 bits so exp+1 never wraps.
  - Left shifts are bounded at exp==1, so the shift count is at most NM+1 cycles.

Decomposition:
- float_pack: add BIAS, EXP_INF (2**NE-1), `ieee_t` packed {s, exp[NE-1:0], frac[NM-1:0]}, the `packer_state_t` enum, and the `fp_flags_t` struct {ovf, unf, inx}.
- Sub-module: float_round_rne, combinational. Takes {mant,g,r,st,exp} and returns {mant,exp,inexact}. The ROUND state registers its output; this sub-module is reused by other result paths.

Test Plan:
- s0 exp=127 mant=0x800000 carry=0 grs=000 -> out_ieee 0x3F800000, flags 000, out_valid 2 edges after accept.
- exp=128 mant=0x400000 -> one left shift, out_ieee 0x3F800000, latency 3. exp=1 mant=0x000001 -> flush 0x00000000, flags 010.
- carry=1 exp=127 mant=0x800000 -> 0x40400000 (3.0), latency 3. carry=1 exp=127 mant=0x800001 -> 0x40400000, inexact=1 (tie, even LSB kept).
- exp=127 mant=0x800001 grs=100 -> 0x3F800002 inexact. exp=127 mant=0x800000 grs=100 -> 0x3F800000 inexact. exp=254 mant=0xFFFFFF grs=110 -> 0x7F800000, flags 101.
- s1 mant=0 grs=000 -> 0x80000000 after 1 edge. Hold out_ready=0 for 5 cycles -> out_valid/out_ieee stable, in_ready=0, second in_valid ignored until the handshake completes.
- rst_i pulsed while in NORM mid-shift -> next cycle out_valid=0, in_ready=1 after rst_i drops, no spurious output. A new operand then converts correctly.
